// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state encoding and shift-amount saturation for alu_mc.
package alu_mc_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Any amount at or beyond the data width behaves like a full-width shift.
  function automatic int unsigned sat_amt(input logic [63:0] b, input int unsigned w);
    return (b >= 64'(w)) ? w : int'(b[31:0]);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response handshake bundle between the operand loader, alu_mc and the result consumer.
interface alu_mc_if #(
  parameter int BUS_REG = 16,
  parameter int BUS_OP  = 6
);
  logic               i_valid;
  logic               o_ready;
  logic [BUS_REG-1:0] i_valA;
  logic [BUS_REG-1:0] i_valB;
  logic [BUS_OP-1:0]  i_opcode;
  logic               o_valid;
  logic               i_ready;
  logic [BUS_REG-1:0] o_result;
  logic               o_zero;
  logic               o_negative;
  logic               o_carry;
  logic               o_overflow;
  logic               o_err;

  modport master (
    output i_valid, i_valA, i_valB, i_opcode, i_ready,
    input  o_ready, o_valid, o_result, o_zero, o_negative, o_carry, o_overflow, o_err
  );

  modport slave (
    input  i_valid, i_valA, i_valB, i_opcode, i_ready,
    output o_ready, o_valid, o_result, o_zero, o_negative, o_carry, o_overflow, o_err
  );
endinterface

// File: rtl/alu_mc_core.sv
// Combinational ADD/SUB/logic datapath with carry/overflow generation; flags legality of non-shift ops.
module alu_mc_core
  import alu_mc_pkg::*;
#(
  parameter int W   = 16,
  parameter int OPW = 6
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [OPW-1:0] op,
  output logic [W-1:0]   res,
  output logic           carry,
  output logic           ovf,
  output logic           legal
);
  logic [W:0] sum;

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    legal = 1'b1;
    sum   = '0;
    case (op)
      OPW'(OP_ADD): begin
        sum   = {1'b0, a} + {1'b0, b};
        res   = sum[W-1:0];
        carry = sum[W];
        ovf   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      OPW'(OP_SUB): begin
        // A + ~B + 1: a missing carry-out means a borrow occurred
        sum   = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        res   = sum[W-1:0];
        carry = ~sum[W];
        ovf   = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
      end
      OPW'(OP_AND): res = a & b;
      OPW'(OP_OR):  res = a | b;
      OPW'(OP_XOR): res = a ^ b;
      OPW'(OP_NOR): res = ~(a | b);
      default:      legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: FSM, handshake, iterative shifter and output registers.
// Define ALU_MC_BARREL_SHIFT_EN to replace the iterative shifter with a one-cycle barrel shifter.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int BUS_REG = 16,
  parameter int BUS_OP  = 6
) (
  input logic    i_clk,
  input logic    i_rst_n,
  alu_mc_if.slave bus
);
`ifdef ALU_MC_BARREL_SHIFT_EN
  localparam bit ITER = 1'b0;
`else
  localparam bit ITER = 1'b1;
`endif
  localparam int CW = $clog2(BUS_REG) + 1;

  state_t              state, state_nxt;
  logic [BUS_REG-1:0]  sh_q, sh_step, bar_res, core_res, ld_res;
  logic [CW-1:0]       cnt_q, amt;
  logic                sra_q, core_c, core_v, core_legal;
  logic                is_shift, is_sra, accept, ld, ld_arith, ld_err;

  alu_mc_core #(.W(BUS_REG), .OPW(BUS_OP)) u_core (
    .a(bus.i_valA), .b(bus.i_valB), .op(bus.i_opcode),
    .res(core_res), .carry(core_c), .ovf(core_v), .legal(core_legal)
  );

  assign is_sra   = bus.i_opcode == BUS_OP'(OP_SRA);
  assign is_shift = is_sra || (bus.i_opcode == BUS_OP'(OP_SRL));
  assign accept   = bus.i_valid && (state == S_IDLE);
  assign amt      = CW'(sat_amt(64'(bus.i_valB), BUS_REG));
  assign sh_step  = {sra_q & sh_q[BUS_REG-1], sh_q[BUS_REG-1:1]};
  assign bar_res  = is_sra ? BUS_REG'($signed(bus.i_valA) >>> amt) : (bus.i_valA >> amt);

  assign bus.o_ready = (state == S_IDLE);
  assign bus.o_valid = (state == S_DONE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.i_valid) state_nxt = (ITER && is_shift && amt != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt_q == CW'(1)) state_nxt = S_DONE;
      S_DONE:  if (bus.i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Selects what, if anything, lands in the output registers this edge.
  always_comb begin
    ld       = 1'b0;
    ld_arith = 1'b0;
    ld_err   = 1'b0;
    ld_res   = core_res;
    if (accept) begin
      if (is_shift) begin
        ld     = !ITER || (amt == '0);
        ld_res = ITER ? bus.i_valA : bar_res;
      end else if (core_legal) begin
        ld       = 1'b1;
        ld_arith = 1'b1;
      end else begin
        ld     = 1'b1;
        ld_err = 1'b1;
        ld_res = '0;
      end
    end else if (state == S_SHIFT && cnt_q == CW'(1)) begin
      ld     = 1'b1;
      ld_res = sh_step;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sh_q           <= '0;
      cnt_q          <= '0;
      sra_q          <= 1'b0;
      bus.o_result   <= '0;
      bus.o_zero     <= 1'b0;
      bus.o_negative <= 1'b0;
      bus.o_carry    <= 1'b0;
      bus.o_overflow <= 1'b0;
      bus.o_err      <= 1'b0;
    end else begin
      if (accept && is_shift) begin
        sh_q  <= bus.i_valA;
        cnt_q <= amt;
        sra_q <= is_sra;
      end else if (state == S_SHIFT) begin
        sh_q  <= sh_step;
        cnt_q <= cnt_q - CW'(1);
      end
      if (ld) begin
        bus.o_result   <= ld_res;
        bus.o_zero     <= !ld_err && (ld_res == '0);
        bus.o_negative <= !ld_err && ld_res[BUS_REG-1];
        bus.o_carry    <= ld_arith && core_c;
        bus.o_overflow <= ld_arith && core_v;
        bus.o_err      <= ld_err;
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Randomised self-checking bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
  import alu_mc_pkg::*;
  localparam int W = 16;
`ifdef ALU_MC_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst_n;
  int   errors = 0;
  int   checks = 0;

  alu_mc_if #(.BUS_REG(W), .BUS_OP(6)) bus ();
  alu_mc #(.BUS_REG(W), .BUS_OP(6)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sext(input int unsigned v);
    return (v & 32'h8000) != 0 ? int'(v) - 65536 : int'(v);
  endfunction

  // fl = {zero, negative, carry, overflow, err}
  function automatic void model(input logic [5:0] op, input int unsigned a, input int unsigned b,
                                output int unsigned res, output logic [4:0] fl, output int lat);
    int unsigned amt = (b > 16) ? 16 : b;
    int ss;
    logic c = 1'b0, v = 1'b0, e = 1'b0;
    lat = 1;
    res = 0;
    case (op)
      OP_ADD: begin res = (a + b) & 32'hFFFF; c = (a + b) > 32'hFFFF;
                    ss = sext(a) + sext(b); v = ss > 32767 || ss < -32768; end
      OP_SUB: begin res = (a - b) & 32'hFFFF; c = a < b;
                    ss = sext(a) - sext(b); v = ss > 32767 || ss < -32768; end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b) & 32'hFFFF;
      OP_SRL: begin res = a >> amt; lat = BARREL ? 1 : 1 + int'(amt); end
      OP_SRA: begin res = int'(sext(a) >>> amt) & 32'hFFFF; lat = BARREL ? 1 : 1 + int'(amt); end
      default: e = 1'b1;
    endcase
    fl = {!e && res == 0, !e && res[15], c, v, e};
  endfunction

  task automatic do_op(input logic [5:0] op, input int unsigned a, input int unsigned b, input int hold);
    int unsigned er;
    logic [4:0] ef;
    int el, lat;
    model(op, a, b, er, ef, el);
    @(negedge i_clk);
    chk("ready_idle", 32'(bus.o_ready), 1);
    bus.i_valid = 1'b1; bus.i_opcode = op; bus.i_valA = 16'(a); bus.i_valB = 16'(b);
    bus.i_ready = (hold == 0);
    @(posedge i_clk);
    #1 bus.i_valid = 1'b0;
    lat = 1;
    @(negedge i_clk);
    while (!bus.o_valid && lat < 40) begin
      chk("busy_not_ready", 32'(bus.o_ready), 0);
      @(negedge i_clk);
      lat++;
    end
    chk($sformatf("lat op=%b b=%0d", op, b), lat, el);
    chk($sformatf("res op=%b a=%h b=%h", op, a, b), {16'h0, bus.o_result}, er);
    chk($sformatf("flags op=%b a=%h b=%h", op, a, b),
        {bus.o_zero, bus.o_negative, bus.o_carry, bus.o_overflow, bus.o_err}, 32'(ef));
    for (int k = 0; k < hold; k++) begin
      bus.i_valid = 1'b1; bus.i_opcode = OP_ADD; bus.i_valA = 16'($urandom); bus.i_valB = 16'($urandom);
      @(negedge i_clk);
      chk("hold_stable", {bus.o_valid, bus.o_ready, bus.o_result, bus.o_zero, bus.o_negative,
                          bus.o_carry, bus.o_overflow, bus.o_err}, {2'b10, 16'(er), ef});
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("back_idle", {bus.o_ready, bus.o_valid}, 2'b10);
  endtask

  initial begin
    logic [5:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA};
    logic [5:0] op;
    int unsigned b;
    i_rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_opcode = '0; bus.i_valA = '0; bus.i_valB = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset", {bus.o_ready, bus.o_valid, bus.o_result, bus.o_zero, bus.o_negative,
                  bus.o_carry, bus.o_overflow, bus.o_err}, {2'b10, 16'h0, 5'b0});
    i_rst_n = 1'b1;

    do_op(OP_ADD, 32'h7FFF, 32'h0001, 0);
    do_op(OP_SUB, 32'h0003, 32'h0005, 0);
    do_op(OP_SUB, 32'h0005, 32'h0005, 0);
    do_op(OP_SRA, 32'h8000, 3, 0);
    do_op(OP_SRL, 32'h8000, 20, 0);
    do_op(OP_SRA, 32'h8001, 16, 0);
    do_op(OP_SRL, 32'h1234, 0, 0);
    do_op(6'b111111, 32'h1234, 32'h5678, 0);
    do_op(OP_ADD, 32'hFFFF, 32'h0001, 0);
    do_op(OP_XOR, 32'hA5A5, 32'h0F0F, 5);

    // Reset landing while an iterative shift is in flight
    @(negedge i_clk);
    bus.i_valid = 1'b1; bus.i_opcode = OP_SRL; bus.i_valA = 16'h8000; bus.i_valB = 16'd10;
    @(posedge i_clk);
    #1 bus.i_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_mid_op", {bus.o_ready, bus.o_valid, bus.o_result, bus.o_zero, bus.o_negative,
                         bus.o_carry, bus.o_overflow, bus.o_err}, {2'b10, 16'h0, 5'b0});
    i_rst_n = 1'b1;

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      b  = (op == OP_SRL || op == OP_SRA) ? $urandom_range(0, 20) : ($urandom & 32'hFFFF);
      do_op(op, $urandom & 32'hFFFF, b, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised ALU with a valid/ready handshake on both sides, registered result and status flags. It succeeds the single-cycle combinational ALU: it is generalised in data width, adds carry/overflow/zero/negative flags and illegal-opcode detection, and executes shifts iteratively to keep the datapath small. It sits between the operand/opcode loading logic (switch/button registers or UART front end) and the result display/transmit stage.

## Interface
- BUS_REG, 16, data width in bits (≥4, power of two)
- BUS_OP, 6, opcode width in bits
- i_clk  in  1  single clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  operands/opcode present
- o_ready  out  1  block can accept a request (high only in IDLE)
- i_valA  in  BUS_REG  operand A
- i_valB  in  BUS_REG  operand B (shift amount for shifts)
- i_opcode  in  BUS_OP  operation select
- o_valid  out  1  result and flags valid
- i_ready  in  1  consumer takes result
- o_result  out  BUS_REG  result
- o_zero, o_negative, o_carry, o_overflow  out  1 each  status flags
- o_err  out  1  opcode was illegal

## Operation
- Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011; all others illegal.
- States: IDLE, SHIFT, DONE.
- IDLE: o_ready=1. Accept on i_valid&o_ready at a rising edge:
  - Non-shift legal op: compute, register result and flags, go DONE.
  - Illegal op: o_result=0, all flags 0, o_err=1, go DONE.
  - Shift: load shift register with i_valA, count = min(i_valB unsigned, BUS_REG); count 0 → DONE with result=i_valA; else → SHIFT.
- SHIFT: one bit position per cycle (SRL fills 0, SRA fills original MSB); count decrements; at count 1 the final shift is registered and the block goes DONE.
- DONE: o_valid=1; outputs held stable until i_valid... consumer handshake o_valid&i_ready → IDLE. i_valid ignored outside IDLE.
- Arithmetic: ADD carry = carry out of MSB; SUB computes A+~B+1, carry = borrow (1 when A<B unsigned); overflow = signed overflow for ADD/SUB, 0 otherwise; carry 0 for logic and shifts; zero = (result==0); negative = result MSB; both 0 when o_err.
- Shift amounts ≥BUS_REG saturate: SRL → 0, SRA → all bits equal to A's MSB.
- Reset (i_rst_n=0 at an edge), including mid-SHIFT or in DONE: state IDLE, pending op discarded, all outputs 0 except o_ready.

## Timing
- Reset values: o_ready=1 (in IDLE), o_valid=0, o_result=0, all flags 0, o_err=0.
- Non-shift/illegal: accept at edge N, o_valid high in cycle after edge N (latency 1).
- Iterative shift: latency 1+count cycles, count = min(shamt, BUS_REG); maximum BUS_REG+1.
- Minimum spacing between accepts: 2 cycles (DONE→IDLE costs one edge), even with i_ready held high.
- o_valid, o_result and flags change only at edges; unchanged while o_valid&!i_ready.

## Configuration
- ALU_MC_BARREL_SHIFT_EN defined: shifts use a combinational barrel shifter and complete like other ops (latency 1); SHIFT state unused.
- Undefined: iterative shifting as described; saturation and flag rules identical in both builds.

## Structure
- Package alu_mc_pkg: opcode localparams, state encoding, helper function for shift-amount saturation.
- Sub-module alu_mc_core: combinational ADD/SUB/logic datapath plus flag generation; alu_mc holds FSM, handshake, shift register and output registers.

## Test plan
- Reset: drive i_rst_n=0 two cycles → o_ready=1, o_valid=0, o_result=0, flags 0.
- ADD 0x7FFF+0x0001 (16-bit) → o_result=0x8000, overflow=1, negative=1, carry=0, o_valid one cycle after accept.
- SUB 0x0003-0x0005 → 0xFFFE, carry(borrow)=1, negative=1; SUB 5-5 → 0, zero=1.
- SRA 0x8000 by 3 → 0xF000 after 4 cycles (iterative); SRL 0x8000 by 20 → 0x0000 after 17 cycles; with macro both at latency 1.
- Opcode 111111 → o_result=0, o_err=1, flags 0; next legal op clears o_err.
- Backpressure: hold i_ready=0 five cycles in DONE → outputs stable, o_ready=0, new i_valid ignored; assert reset mid-SHIFT → IDLE next cycle, o_valid=0.
